// File: rtl/vga_timing_pkg.sv
// 640x480 @ 60 Hz raster timing constants, coordinate type and output record.
// Purely declarative: no logic, no latency, no flow control.
// Shared by vga_sync_gen and vga_axis_counter.
package vga_timing_pkg;

    localparam int COORD_W = 11;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HSYNC_START = H_ACTIVE + H_FP;
    localparam int HSYNC_END   = HSYNC_START + H_SYNC;
    localparam int VSYNC_START = V_ACTIVE + V_FP;
    localparam int VSYNC_END   = VSYNC_START + V_SYNC;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic   hsync;
        logic   vsync;
        logic   activevideo;
        coord_t x;
        coord_t y;
    } raster_t;

    // Pin level for a sync pulse given whether it is asserted and the polarity.
    function automatic logic sync_level(input logic asserted, input logic active_low);
        return asserted ^ active_low;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrap-around counter with terminal count and active/sync window decode.
// Count updates on the enabled edge; tc/active/in_sync decode the current count combinationally.
// No backpressure: counts whenever en is high.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL      = H_TOTAL,
    parameter int ACTIVE     = H_ACTIVE,
    parameter int SYNC_START = HSYNC_START,
    parameter int SYNC_END   = HSYNC_END
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    output coord_t cnt,
    output logic   tc,
    output logic   active,
    output logic   in_sync
);

    localparam coord_t LAST   = coord_t'(TOTAL - 1);
    localparam coord_t ACT_LIM = coord_t'(ACTIVE);
    localparam coord_t SS     = coord_t'(SYNC_START);
    localparam coord_t SE     = coord_t'(SYNC_END);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + coord_t'(1);
        end
    end

    assign tc      = (cnt == LAST);
    assign active  = (cnt < ACT_LIM);
    assign in_sync = (cnt >= SS) && (cnt < SE);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator (hsync/vsync/activevideo/x_px/y_px); VGA_CLK_DIV2_EN runs it from a 2x clock.
// Outputs are registered one pixel-enable edge after the counters, all from the same (hc, vc) pair.
// No backpressure: free-running; reset restarts at frame origin.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE        = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP            = vga_timing_pkg::H_FP,
    parameter int H_SYNC          = vga_timing_pkg::H_SYNC,
    parameter int H_BP            = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE        = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP            = vga_timing_pkg::V_FP,
    parameter int V_SYNC          = vga_timing_pkg::V_SYNC,
    parameter int V_BP            = vga_timing_pkg::V_BP,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic               clk,
    input  logic               rst,
    output logic               hsync,
    output logic               vsync,
    output logic [COORD_W-1:0] x_px,
    output logic [COORD_W-1:0] y_px,
    output logic               activevideo,
    output logic               px_clk
);

    localparam int   H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int   V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int   HS_START = H_ACTIVE + H_FP;
    localparam int   VS_START = V_ACTIVE + V_FP;
    localparam logic SYNC_LOW = (SYNC_ACTIVE_LOW != 0);

    logic    pe;
    coord_t  hc, vc;
    logic    h_tc, h_act, h_sync_win;
    logic    v_tc_unused, v_act, v_sync_win;
    raster_t q;

`ifdef VGA_CLK_DIV2_EN
    logic pe_tgl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pe_tgl <= 1'b0;
        end else begin
            pe_tgl <= ~pe_tgl;
        end
    end

    assign pe     = pe_tgl;
    assign px_clk = pe_tgl;
`else
    assign pe     = 1'b1;
    assign px_clk = clk;
`endif

    vga_axis_counter #(
        .TOTAL      (H_TOT),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (HS_START),
        .SYNC_END   (HS_START + H_SYNC)
    ) u_hcnt (
        .clk     (clk),
        .rst     (rst),
        .en      (pe),
        .cnt     (hc),
        .tc      (h_tc),
        .active  (h_act),
        .in_sync (h_sync_win)
    );

    // Vertical axis steps once per line, on the horizontal wrap edge.
    vga_axis_counter #(
        .TOTAL      (V_TOT),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (VS_START),
        .SYNC_END   (VS_START + V_SYNC)
    ) u_vcnt (
        .clk     (clk),
        .rst     (rst),
        .en      (pe & h_tc),
        .cnt     (vc),
        .tc      (v_tc_unused),
        .active  (v_act),
        .in_sync (v_sync_win)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q.x           <= '0;
            q.y           <= '0;
            q.activevideo <= 1'b0;
            q.hsync       <= sync_level(1'b0, SYNC_LOW);
            q.vsync       <= sync_level(1'b0, SYNC_LOW);
        end else if (pe) begin
            q.x           <= hc;
            q.y           <= vc;
            q.activevideo <= h_act & v_act;
            q.hsync       <= sync_level(h_sync_win, SYNC_LOW);
            q.vsync       <= sync_level(v_sync_win, SYNC_LOW);
        end
    end

    assign hsync       = q.hsync;
    assign vsync       = q.vsync;
    assign x_px        = q.x;
    assign y_px        = q.y;
    assign activevideo = q.activevideo;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: standard 640x480 instance plus a short-frame, active-high-sync instance.
// Build with +define+VGA_CLK_DIV2_EN to exercise the 2x clock mode.
module tb_vga_sync_gen;

`ifdef VGA_CLK_DIV2_EN
    localparam int DIV = 2;
`else
    localparam int DIV = 1;
`endif
    localparam int KPE = 20900;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        av;
        logic        hs;
        logic        vs;
    } obs_t;

    typedef struct {
        int cyc;
        int x;
        int y;
        bit av;
        bit hs;
        bit vs;
    } vec_t;

    logic        clk;
    logic        rst = 1'b1;
    logic        hs_a, vs_a, av_a, pclk_a;
    logic        hs_b, vs_b, av_b, pclk_b;
    logic [10:0] x_a, y_a, x_b, y_b;

    int n_checks = 0;
    int n_pass   = 0;

    obs_t qa[$];
    obs_t qb[$];
    int   mhc = 0, mvc_a = 0, mvc_b = 0;
    bit   mtgl = 1'b0;

    vga_sync_gen u_dut_a (
        .clk(clk), .rst(rst), .hsync(hs_a), .vsync(vs_a), .x_px(x_a), .y_px(y_a),
        .activevideo(av_a), .px_clk(pclk_a)
    );

    vga_sync_gen #(
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_ACTIVE_LOW(0)
    ) u_dut_b (
        .clk(clk), .rst(rst), .hsync(hs_b), .vsync(vs_b), .x_px(x_b), .y_px(y_b),
        .activevideo(av_b), .px_clk(pclk_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got x=%0d y=%0d av=%b hs=%b vs=%b, required x=%0d y=%0d av=%b hs=%b vs=%b",
                      name, act.x, act.y, act.av, act.hs, act.vs, exp.x, exp.y, exp.av, exp.hs, exp.vs);
    endtask

    function automatic obs_t model(input int hc, input int vc, input int vact,
                                   input int vss, input int vse, input bit low);
        obs_t o;
        bit   hon, von;
        o.x  = hc[10:0];
        o.y  = vc[10:0];
        o.av = (hc < 640) && (vc < vact);
        hon  = (hc >= 656) && (hc < 752);
        von  = (vc >= vss) && (vc < vse);
        o.hs = low ? !hon : hon;
        o.vs = low ? !von : von;
        return o;
    endfunction

    function automatic obs_t obs_a();
        return {x_a, y_a, av_a, hs_a, vs_a};
    endfunction

    function automatic obs_t obs_b();
        return {x_b, y_b, av_b, hs_b, vs_b};
    endfunction

    // Scoreboard producer: model advances on each pixel-enable edge and queues what the DUT must show.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                mhc = 0; mvc_a = 0; mvc_b = 0; mtgl = 1'b0;
                qa.delete(); qb.delete();
            end else begin
                if (DIV == 1 || mtgl) begin
                    qa.push_back(model(mhc, mvc_a, 480, 490, 492, 1'b1));
                    qb.push_back(model(mhc, mvc_b, 6, 8, 10, 1'b0));
                    if (mhc == 799) begin
                        mhc   = 0;
                        mvc_a = (mvc_a == 524) ? 0 : mvc_a + 1;
                        mvc_b = (mvc_b == 12) ? 0 : mvc_b + 1;
                    end else begin
                        mhc++;
                    end
                end
                mtgl = !mtgl;
            end
        end
    end

    // Scoreboard consumer: compare away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (qa.size() > 0) check_obs("sb_a", obs_a(), qa.pop_front());
                if (qb.size() > 0) check_obs("sb_b", obs_b(), qb.pop_front());
                if (DIV == 1) check_int("px_clk", int'(pclk_a), int'(clk));
                else          check_int("px_clk", int'(pclk_a), int'(mtgl));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        int   cur;
        obs_t e;
        int   prev_hs_a, prev_vs_b, prev_y_b, last_fall, hs_n, hs_jit, vs_hi;
        int   rise_x, rise_y;
        int   vs_rise[$];
        int   wrap[$];

        // cycle = pixel-enable edges since reset release
        tbl[0] = '{1,    0,   0, 1'b1, 1'b1, 1'b1};
        tbl[1] = '{640,  639, 0, 1'b1, 1'b1, 1'b1};
        tbl[2] = '{641,  640, 0, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{656,  655, 0, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{657,  656, 0, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{752,  751, 0, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{753,  752, 0, 1'b0, 1'b1, 1'b1};
        tbl[7] = '{800,  799, 0, 1'b0, 1'b1, 1'b1};
        tbl[8] = '{801,  0,   1, 1'b1, 1'b1, 1'b1};
        tbl[9] = '{1601, 0,   2, 1'b1, 1'b1, 1'b1};

        repeat (3) @(negedge clk);
        #1;
        check_obs("reset_a", obs_a(), obs_t'({11'd0, 11'd0, 1'b0, 1'b1, 1'b1}));
        check_obs("reset_b", obs_b(), obs_t'({11'd0, 11'd0, 1'b0, 1'b0, 1'b0}));
        @(negedge clk);
        rst = 1'b0;

        cur = 0;
        for (int i = 0; i < 10; i++) begin
            repeat (tbl[i].cyc * DIV - cur) @(posedge clk);
            cur = tbl[i].cyc * DIV;
            #1;
            e = {tbl[i].x[10:0], tbl[i].y[10:0], tbl[i].av, tbl[i].hs, tbl[i].vs};
            check_obs($sformatf("vec%0d", i), obs_a(), e);
            check_int($sformatf("vec%0d_hs_b", i), int'(hs_b), int'(!tbl[i].hs));
        end

        // Asynchronous reset in the middle of a line.
        repeat (299 * DIV) @(posedge clk);
        #1;
        check_int("pre_rst_x", int'(x_a), 299);
        check_int("pre_rst_y", int'(y_a), 2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_obs("midrst_a", obs_a(), obs_t'({11'd0, 11'd0, 1'b0, 1'b1, 1'b1}));
        check_obs("midrst_b", obs_b(), obs_t'({11'd0, 11'd0, 1'b0, 1'b0, 1'b0}));
        @(negedge clk);
        rst = 1'b0;
        if (DIV == 2) begin
            @(posedge clk);
            #1;
            check_int("div2_hold_av", int'(av_a), 0);
        end
        @(posedge clk);
        #1;
        check_obs("restart_a", obs_a(), obs_t'({11'd0, 11'd0, 1'b1, 1'b1, 1'b1}));

        // Two short frames on instance B; line timing watched on instance A.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        prev_hs_a = 1; prev_vs_b = 0; prev_y_b = 0; last_fall = -1;
        hs_n = 0; hs_jit = 0; vs_hi = 0; rise_x = -1; rise_y = -1;
        for (int ed = 1; ed <= KPE * DIV; ed++) begin
            @(posedge clk);
            #1;
            if (prev_hs_a == 1 && hs_a == 1'b0) begin
                if (last_fall >= 0 && ed - last_fall != 800 * DIV) hs_jit++;
                last_fall = ed;
                hs_n++;
            end
            if (prev_vs_b == 0 && vs_b == 1'b1) begin
                vs_rise.push_back(ed);
                if (vs_rise.size() == 1) begin
                    rise_x = int'(x_b);
                    rise_y = int'(y_b);
                end
            end
            if (vs_b) vs_hi++;
            if (prev_y_b == 12 && y_b == 11'd0) wrap.push_back(ed);
            prev_hs_a = int'(hs_a);
            prev_vs_b = int'(vs_b);
            prev_y_b  = int'(y_b);
        end
        check_int("hs_jitter", hs_jit, 0);
        check_int("hs_pulses", hs_n, 26);
        check_int("vs_rises", vs_rise.size(), 2);
        check_int("vs_first", vs_rise.size() >= 1 ? vs_rise[0] : -1, 6401 * DIV);
        check_int("vs_first_y", rise_y, 8);
        check_int("vs_first_x", rise_x, 0);
        check_int("vs_period", vs_rise.size() >= 2 ? vs_rise[1] - vs_rise[0] : -1, 10400 * DIV);
        check_int("vs_width", vs_hi, 3200 * DIV);
        check_int("y_wraps", wrap.size(), 2);
        check_int("y_wrap_first", wrap.size() >= 1 ? wrap[0] : -1, 10401 * DIV);
        check_int("frame_period", wrap.size() >= 2 ? wrap[1] - wrap[0] : -1, 10400 * DIV);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
